// File: rtl/tcp_tx_seg_engine.sv
// -----------------------------------------------------------------------------
// tcp_tx_seg_engine
//
// Per-flow TCP transmit segment engine. A scheduler grant selects a flow. The
// engine then reads that flow's state and sizes one segment. The segment size
// is the smallest of the buffered bytes, the MSS and the peer window; the
// window is ignored for a retransmit. The engine emits the header fields and
// a payload descriptor, writes back the next sequence number and finally
// tells the scheduler which pending flags to clear.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   sched_req_*               grant handshake (flow id, retransmit, pure-ack)
//   st_rd_val / st_rd_addr    flow-state read strobe and address; the
//                             response arrives on st_* exactly one cycle later
//   st_tail_ptr .. st_peer_win  flow-state read response
//   st_wr_val / st_wr_seq     one-cycle write-back of the new our_seq
//   pkt_*                     segment header + payload descriptor (val/rdy)
//   upd_*                     flag-clear command back to the scheduler (val/rdy)
//
// Sequence: IDLE -> RD -> CALC -> [EMIT] -> WB -> IDLE
// -----------------------------------------------------------------------------
module tcp_tx_seg_engine #(
    parameter int FLOWID_W  = 6,
    parameter int PTR_W     = 16,
    parameter int SEQ_W     = 32,
    parameter int MSS       = 1460,
    parameter int GO_BACK_N = 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                sched_req_val,
    output logic                sched_req_rdy,
    input  logic [FLOWID_W-1:0] sched_req_flowid,
    input  logic                sched_req_rt,
    input  logic                sched_req_ack,

    output logic                st_rd_val,
    output logic [FLOWID_W-1:0] st_rd_addr,
    input  logic [PTR_W:0]      st_tail_ptr,
    input  logic [SEQ_W-1:0]    st_our_seq,
    input  logic [SEQ_W-1:0]    st_una,
    input  logic [SEQ_W-1:0]    st_their_ack,
    input  logic [15:0]         st_peer_win,

    output logic                st_wr_val,
    output logic [SEQ_W-1:0]    st_wr_seq,

    output logic                pkt_val,
    input  logic                pkt_rdy,
    output logic [FLOWID_W-1:0] pkt_flowid,
    output logic [SEQ_W-1:0]    pkt_seq,
    output logic [SEQ_W-1:0]    pkt_ack,
    output logic [7:0]          pkt_flags,
    output logic [PTR_W-1:0]    pkt_pay_addr,
    output logic [PTR_W:0]      pkt_pay_len,

    output logic                upd_val,
    input  logic                upd_rdy,
    output logic [FLOWID_W-1:0] upd_flowid,
    output logic                upd_clr_rt,
    output logic                upd_clr_ack,
    output logic                upd_clr_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CALC = 3'd2,
        S_EMIT = 3'd3,
        S_WB   = 3'd4
    } state_t;

    localparam logic [PTR_W:0] MSS_LEN = (PTR_W+1)'(MSS);

    state_t state_reg, state_next;

    // Keeps the grant port closed while reset is asserted. It opens on the
    // first clock edge after reset is released.
    logic run_reg;

    logic [FLOWID_W-1:0] flowid_reg;
    logic                rt_reg;
    logic                ack_reg;
    logic [SEQ_W-1:0]    seq_reg;
    logic [SEQ_W-1:0]    hdr_ack_reg;
    logic [SEQ_W-1:0]    wr_seq_reg;
    logic [PTR_W:0]      len_reg;
    logic                sent_reg;
    logic                clr_data_reg;
    logic                wr_done_reg;

    // ---------------- segment sizing (valid during CALC) -----------------
    logic [SEQ_W-1:0] base_seq;
    logic [SEQ_W-1:0] inflight;
    logic [SEQ_W-1:0] win_ext;
    logic [SEQ_W-1:0] room;
    logic [PTR_W:0]   avail;
    logic [PTR_W:0]   cap;
    logic [PTR_W:0]   len_calc;
    logic [SEQ_W-1:0] len_ext;
    logic [SEQ_W-1:0] wr_seq_calc;
    logic             emit_calc;
    logic             clr_data_calc;

    always_comb begin
        base_seq = rt_reg ? st_una : st_our_seq;
        // Pointer and sequence differences are modular, so wrap needs no
        // special handling.
        avail    = st_tail_ptr - base_seq[PTR_W:0];
        inflight = st_our_seq - st_una;
        win_ext  = SEQ_W'(st_peer_win);
        room     = (win_ext > inflight) ? (win_ext - inflight) : '0;
        cap      = (avail < MSS_LEN) ? avail : MSS_LEN;
        // A retransmit resends bytes the peer has already admitted, so the
        // window does not clamp it.
        if (!rt_reg && (room < SEQ_W'(cap))) begin
            len_calc = room[PTR_W:0];
        end else begin
            len_calc = cap;
        end
        len_ext = SEQ_W'(len_calc);
        if (!rt_reg) begin
            wr_seq_calc = st_our_seq + len_ext;
        end else if (GO_BACK_N != 0) begin
            wr_seq_calc = st_una + len_ext;
        end else begin
            wr_seq_calc = st_our_seq;
        end
        emit_calc     = rt_reg | ack_reg | (len_calc != '0);
        clr_data_calc = !rt_reg && (len_calc == avail);
    end

    // ---------------- FSM state register ---------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
        end
    end

    // ---------------- FSM next state / handshake outputs -----------------
    always_comb begin
        state_next    = state_reg;
        sched_req_rdy = 1'b0;
        st_rd_val     = 1'b0;
        pkt_val       = 1'b0;
        upd_val       = 1'b0;
        st_wr_val     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                sched_req_rdy = run_reg;
                if (sched_req_val && run_reg) begin
                    state_next = S_RD;
                end
            end
            S_RD: begin
                st_rd_val  = 1'b1;
                state_next = S_CALC;
            end
            S_CALC: begin
                state_next = emit_calc ? S_EMIT : S_WB;
            end
            S_EMIT: begin
                pkt_val = 1'b1;
                if (pkt_rdy) begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                upd_val   = 1'b1;
                // The write-back fires once even if upd_rdy stalls.
                st_wr_val = !wr_done_reg;
                if (upd_rdy) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- datapath registers ---------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flowid_reg   <= '0;
            rt_reg       <= 1'b0;
            ack_reg      <= 1'b0;
            seq_reg      <= '0;
            hdr_ack_reg  <= '0;
            wr_seq_reg   <= '0;
            len_reg      <= '0;
            sent_reg     <= 1'b0;
            clr_data_reg <= 1'b0;
            wr_done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (sched_req_val && run_reg) begin
                        flowid_reg <= sched_req_flowid;
                        rt_reg     <= sched_req_rt;
                        ack_reg    <= sched_req_ack;
                    end
                end
                S_CALC: begin
                    seq_reg      <= base_seq;
                    hdr_ack_reg  <= st_their_ack;
                    wr_seq_reg   <= wr_seq_calc;
                    len_reg      <= len_calc;
                    sent_reg     <= emit_calc;
                    clr_data_reg <= clr_data_calc;
                    wr_done_reg  <= 1'b0;
                end
                S_WB: begin
                    wr_done_reg <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- registered output fields ---------------------------
    assign st_rd_addr   = flowid_reg;
    assign st_wr_seq    = wr_seq_reg;
    assign pkt_flowid   = flowid_reg;
    assign pkt_seq      = seq_reg;
    assign pkt_ack      = hdr_ack_reg;
    assign pkt_flags    = (len_reg != '0) ? 8'h18 : 8'h10;
    assign pkt_pay_addr = seq_reg[PTR_W-1:0];
    assign pkt_pay_len  = len_reg;
    assign upd_flowid   = flowid_reg;
    assign upd_clr_rt   = rt_reg;
    assign upd_clr_ack  = sent_reg;
    assign upd_clr_data = clr_data_reg;

endmodule
